// File: rtl/prog_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : prog_loader                                                     |
// | Purpose  : Boot loader. Receives a byte stream made of a 32-bit word count |
// |            followed by little-endian 32-bit words. Each word is written to |
// |            instruction memory at word addresses counting up from 0. The   |
// |            cpu is held in reset until the whole image has been written.   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module prog_loader #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  s_valid,
    input  logic [7:0]            s_data,
    output logic                  s_ready,
    input  logic                  load_req,
    output logic                  imem_wr_en,
    output logic [ADDR_WIDTH-1:0] imem_wr_addr,
    output logic [31:0]           imem_wr_data,
    output logic                  cpu_resetn,
    output logic                  done,
    output logic                  error
);

    localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_HDR   = 3'd0,
        S_DATA  = 3'd1,
        S_FLUSH = 3'd2,
        S_DONE  = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [1:0]            r_byte_cnt;
    logic [31:0]           r_count;
    logic [31:0]           r_word;
    // One extra bit so that an image of exactly MAX_WORDS words can be counted
    logic [ADDR_WIDTH:0]   r_word_idx;

    logic                  w_xfer;
    logic                  w_last_byte;
    logic                  w_last_word;
    logic                  w_restart;
    logic [31:0]           w_hdr;
    logic [31:0]           w_assembled;

    assign s_ready     = (r_state == S_HDR) || (r_state == S_DATA);
    assign w_xfer      = s_valid && s_ready;
    assign w_last_byte = w_xfer && (r_byte_cnt == 2'd3);
    // Bytes arrive LSB first, so shifting in from the top leaves byte 0 at 7:0
    assign w_hdr       = {s_data, r_count[31:8]};
    assign w_assembled = {s_data, r_word[31:8]};
    // r_count is at least 1 whenever DATA is active, so count-1 cannot wrap
    assign w_last_word = (32'(r_word_idx) == (r_count - 32'd1));
    assign w_restart   = load_req && ((r_state == S_DONE) || (r_state == S_ERROR));

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_HDR;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_HDR: begin
                if (w_last_byte) begin
                    if (w_hdr == 32'd0) begin
                        w_next = S_DONE;
                    end else if (w_hdr > MAX_WORDS) begin
                        w_next = S_ERROR;
                    end else begin
                        w_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_last_byte && w_last_word) begin
                    w_next = S_FLUSH;
                end
            end
            S_FLUSH: w_next = S_DONE;
            S_DONE:  if (load_req) w_next = S_HDR;
            S_ERROR: if (load_req) w_next = S_HDR;
            default: w_next = S_HDR;
        endcase
    end

    // Byte assembly, word counting, memory write port and registered status
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_byte_cnt   <= 2'd0;
            r_count      <= 32'd0;
            r_word       <= 32'd0;
            r_word_idx   <= '0;
            imem_wr_en   <= 1'b0;
            imem_wr_addr <= '0;
            imem_wr_data <= 32'd0;
            cpu_resetn   <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            imem_wr_en <= 1'b0;

            if (w_xfer) begin
                r_byte_cnt <= r_byte_cnt + 2'd1;
                if (r_state == S_HDR) begin
                    r_count <= w_hdr;
                end else begin
                    r_word <= w_assembled;
                end
            end

            if ((r_state == S_HDR) && w_last_byte) begin
                r_word_idx <= '0;
            end

            if ((r_state == S_DATA) && w_last_byte) begin
                imem_wr_en   <= 1'b1;
                imem_wr_addr <= r_word_idx[ADDR_WIDTH-1:0];
                imem_wr_data <= w_assembled;
                r_word_idx   <= r_word_idx + 1'b1;
            end

            if (w_restart) begin
                r_byte_cnt <= 2'd0;
                r_word_idx <= '0;
            end

            // Status follows the state being entered so it changes on the
            // same edge as the transition itself
            cpu_resetn <= (w_next == S_DONE);
            done       <= (w_next == S_DONE);
            error      <= (w_next == S_ERROR);
        end
    end

endmodule
`default_nettype wire

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader sitting upstream of the instruction memory and the cpu's reset input. Accepts a byte stream over a valid/ready handshake carrying a word-count header followed by little-endian 32-bit instruction words. Writes each word into instruction memory at consecutive word addresses from 0, and holds the cpu in reset until the whole image has been written. Replaces bench-side hex preloading for system-level runs and FPGA boot.

## Interface
- ADDR_WIDTH, 10, instruction memory word-address width; MAX_WORDS = 2**ADDR_WIDTH.
- clk  in  1  system clock, all state updates on rising edge.
- resetn  in  1  one clock; reset is asynchronous and active-low.
- s_valid  in  1  upstream byte valid.
- s_data  in  8  upstream byte.
- s_ready  out  1  loader can accept a byte; transfer occurs on a rising edge with s_valid && s_ready.
- load_req  in  1  restart loading; honoured only in DONE or ERROR.
- imem_wr_en  out  1  one-cycle instruction memory write strobe.
- imem_wr_addr  out  ADDR_WIDTH  word address of the write.
- imem_wr_data  out  32  instruction word to write.
- cpu_resetn  out  1  active-low reset to cpu; low while loading.
- done  out  1  image fully written, cpu released.
- error  out  1  header word count exceeded MAX_WORDS.

## Operation
- Stream format: bytes 0-3 form N (32-bit word count, byte 0 = bits 7:0), then N words of 4 bytes each, byte 0 = bits 7:0.
- States: HDR, DATA, FLUSH, DONE, ERROR. Reset enters HDR.
- s_ready = 1 in HDR and DATA only; 0 in FLUSH, DONE, ERROR.
- HDR: collect 4 bytes into count register. On 4th byte: N == 0 -> DONE; N > MAX_WORDS -> ERROR; otherwise -> DATA with word index 0.
- DATA: collect 4 bytes into word shift register. On 4th byte: register imem_wr_en=1, imem_wr_addr=word index, imem_wr_data=assembled word; increment word index. If this was word N-1 -> FLUSH, else stay in DATA.
- FLUSH: exactly one cycle (final write strobe visible) -> DONE.
- DONE: cpu_resetn=1, done=1. load_req=1 -> HDR, cpu_resetn=0, done=0, byte and word counters cleared.
- ERROR: error=1, cpu_resetn=0, nothing written further. load_req=1 -> HDR, error cleared.
- Partial words/headers retained across s_valid gaps of any length; byte counter (2 bits) advances only on handshakes.
- load_req ignored in HDR, DATA, FLUSH.
- Word index is ADDR_WIDTH+1 bits wide internally so N == MAX_WORDS is legal; the final write goes to address MAX_WORDS-1, no wrap.

## Timing
- Reset values: s_ready=1 (state HDR), imem_wr_en=0, imem_wr_addr=0, imem_wr_data=0, cpu_resetn=0, done=0, error=0; all counters 0.
- Reset asserted mid-load: immediately returns to HDR, cpu_resetn low, pending partial word discarded, no write strobe.
- Write latency: 4th byte of a word accepted at edge k -> imem_wr_en high for the cycle between edge k and k+1, then low unless the next word completes at k+1 (impossible: minimum 4 edges per word).
- Last word at edge k: FLUSH during k..k+1, cpu_resetn and done rise at edge k+1 (memory write lands at k+1, first fetch follows).
- N == 0: cpu_resetn and done rise at edge of 4th header byte.
- N > MAX_WORDS: error rises at edge of 4th header byte; s_ready low from then.
- load_req sampled at edge e in DONE/ERROR: cpu_resetn low, done/error low, s_ready high from e; no byte accepted at edge e itself.
- All outputs registered except s_ready (decoded from state register).

## Test plan
- Stream 03 00 00 00, 13 05 f0 7f, 93 05 00 80, 6f 00 00 00 -> writes 0x7FF00513 @0, 0x800005_93 @1, 0x0000006F @2, one strobe each; cpu_resetn/done high one edge after last strobe.
- Same stream with random s_valid gaps (0-7 idle cycles) -> identical writes and addresses; no spurious strobes.
- Header 00 00 00 00 -> no writes; done=1, cpu_resetn=1 at 4th header edge.
- ADDR_WIDTH=4, header 11 00 00 00 (N=17) -> error=1, s_ready=0, cpu_resetn=0, no writes; N=16 -> 16 writes, last at address 15, done=1.
- Load 2 words, pulse load_req in DONE, load 1 word 0xDEADBEEF -> cpu_resetn low during reload, write @0 = 0xDEADBEEF, done again.
- Assert resetn low after 6 bytes of a 2-word image, then resend full image -> no write from aborted attempt; correct writes @0, @1 afterward.
